// File: rtl/apb_wdog_multi_if.sv
// APB slave bus bundle for the multi-channel watchdog.
// Only the handshake and data signals live here; clock and reset stay plain ports.
interface apb_wdog_multi_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:2] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_wdog_multi.sv
// APB watchdog with NUM_CH independent down-counters, per-channel interrupt masking,
// a shared write lock, an aggregated interrupt output and a shared count tick.
module apb_wdog_multi #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [3:0]  ECOREVNUM = 4'h0
) (
  input  logic              pclk,
  input  logic              preset,
  apb_wdog_multi_if.slave   apb,
  input  logic              wdogclken,
  output logic [NUM_CH-1:0] wdogint,
  output logic              wdogint_any,
  output logic [NUM_CH-1:0] wdogres
);

  localparam logic [31:0] UNLOCK_KEY = 32'h1ACCE551;
  localparam logic [9:0]  LOCK_ADDR  = 10'h300;
  localparam logic [9:0]  ID_ADDR    = 10'h301;

  logic       wr_en;
  logic [6:0] ch_sel;
  logic [2:0] reg_off;
  logic       locked_q;

  logic [CNT_W-1:0] load_a [NUM_CH];
  logic [CNT_W-1:0] cnt_a  [NUM_CH];
  logic [1:0]       ctrl_a [NUM_CH];
  logic [NUM_CH-1:0] ris_a;

  logic [31:0] rdata;

  assign wr_en   = apb.psel & apb.penable & apb.pwrite;
  assign ch_sel  = apb.paddr[11:5];
  assign reg_off = apb.paddr[4:2];

  // Any write other than the key re-locks; the lock register itself is never locked.
  always_ff @(posedge pclk) begin
    if (preset) begin
      locked_q <= 1'b0;
    end else if (wr_en && (apb.paddr == LOCK_ADDR)) begin
      locked_q <= (apb.pwdata != UNLOCK_KEY);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] load_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       ctrl_r;
    logic             ris_r;
    logic             res_r;
    logic             int_r;
    logic             sel;
    logic             load_wr;
    logic             ctrl_wr;
    logic             clr_wr;
    logic             tick;
    logic             zero_ev;

    assign sel     = wr_en & ~locked_q & (ch_sel == 7'(c));
    assign load_wr = sel & (reg_off == 3'd0);
    assign ctrl_wr = sel & (reg_off == 3'd2);
    assign clr_wr  = sel & (reg_off == 3'd3);
    assign tick    = ctrl_r[0] & wdogclken;
    assign zero_ev = tick & (cnt_r == '0);

    // A zero event beats INTCLR for RIS, while INTCLR beats the reset request.
    always_ff @(posedge pclk) begin
      if (preset) begin
        load_r <= '1;
        cnt_r  <= '1;
        ctrl_r <= 2'b00;
        ris_r  <= 1'b0;
        res_r  <= 1'b0;
        int_r  <= 1'b0;
      end else begin
        if (load_wr) begin
          load_r <= apb.pwdata[CNT_W-1:0];
        end
        if (ctrl_wr) begin
          ctrl_r <= apb.pwdata[1:0];
        end

        if (load_wr) begin
          cnt_r <= apb.pwdata[CNT_W-1:0];
        end else if (clr_wr || zero_ev || (ctrl_wr && apb.pwdata[0] && !ctrl_r[0])) begin
          cnt_r <= load_r;
        end else if (tick) begin
          cnt_r <= cnt_r - CNT_W'(1);
        end

        if (zero_ev) begin
          ris_r <= 1'b1;
        end else if (clr_wr) begin
          ris_r <= 1'b0;
        end

        if (clr_wr) begin
          res_r <= 1'b0;
        end else if (zero_ev && ris_r && ctrl_r[1]) begin
          res_r <= 1'b1;
        end

        int_r <= ris_r & ctrl_r[0];
      end
    end

    assign load_a[c]  = load_r;
    assign cnt_a[c]   = cnt_r;
    assign ctrl_a[c]  = ctrl_r;
    assign ris_a[c]   = ris_r;
    assign wdogint[c] = int_r;
    assign wdogres[c] = res_r;
  end

  assign wdogint_any = |wdogint;

  // Channel windows sit below the lock/ID block, so the two decodes never overlap.
  always_comb begin
    rdata = '0;
    if (apb.psel) begin
      if (apb.paddr == LOCK_ADDR) begin
        rdata[0] = locked_q;
      end else if (apb.paddr == ID_ADDR) begin
        rdata = {16'h5744, 12'h000, ECOREVNUM};
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel == 7'(c)) begin
            case (reg_off)
              3'd0:    rdata[CNT_W-1:0] = load_a[c];
              3'd1:    rdata[CNT_W-1:0] = cnt_a[c];
              3'd2:    rdata[1:0]       = ctrl_a[c];
              3'd4:    rdata[0]         = ris_a[c];
              3'd5:    rdata[0]         = ris_a[c] & ctrl_a[c][0];
              default: rdata            = '0;
            endcase
          end
        end
      end
    end
  end

  assign apb.prdata = rdata;
  assign apb.pready = 1'b1;

endmodule

// File: tb/tb_apb_wdog_multi.sv
// Directed scoreboard bench for apb_wdog_multi: lock, counting, masking,
// boundary LOAD=0, coincident INTCLR/zero event and reset during a write.
module tb_apb_wdog_multi;
  localparam int         NUM_CH = 4;
  localparam int         CNT_W  = 32;
  localparam logic [3:0] REV    = 4'h3;
  localparam logic [31:0] KEY   = 32'h1ACCE551;

  logic              pclk = 1'b0;
  logic              preset;
  logic              wdogclken;
  logic [NUM_CH-1:0] wdogint;
  logic              wdogint_any;
  logic [NUM_CH-1:0] wdogres;

  apb_wdog_multi_if apb ();

  apb_wdog_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .ECOREVNUM(REV)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .apb        (apb.slave),
    .wdogclken  (wdogclken),
    .wdogint    (wdogint),
    .wdogint_any(wdogint_any),
    .wdogres    (wdogres)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic pushExpect(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: observed %h required none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
  endtask

  // APB write: setup edge then access edge, which is where the write commits.
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b1;
    apb.paddr   = addr[11:2];
    apb.pwdata  = data;
    @(posedge pclk);
    #1 apb.penable = 1'b1;
    @(posedge pclk);
    #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  task automatic readReg(input logic [11:0] addr, output logic [31:0] d);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = addr[11:2];
    #1 d = apb.prdata;
    apb.psel = 1'b0;
  endtask

  task automatic checkRead(input string tag, input logic [11:0] addr, input logic [31:0] val);
    logic [31:0] d;
    pushExpect(tag, val);
    readReg(addr, d);
    checkOutput(d);
  endtask

  task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] val);
    pushExpect(tag, val);
    checkOutput(obs);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed running required finished");
    $fatal(1, "[TB] simulation time limit hit");
  end

  initial begin
    logic [31:0] d;
    preset      = 1'b1;
    wdogclken   = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;

    checkSig("rst_wdogint", 32'(wdogint), 32'h0);
    checkSig("rst_wdogres", 32'(wdogres), 32'h0);
    checkSig("rst_any", 32'(wdogint_any), 32'h0);
    checkSig("pready", 32'(apb.pready), 32'h1);
    checkRead("rst_load0", 12'h000, 32'hFFFF_FFFF);
    checkRead("rst_value0", 12'h004, 32'hFFFF_FFFF);
    tick(1);
    checkRead("rst_ctrl0", 12'h008, 32'h0);
    checkRead("rst_lock", 12'hC00, 32'h0);

    // Channel 0 counts 5..0, interrupts, then requests reset on the second timeout.
    applyStimulus(12'hC00, KEY);
    applyStimulus(12'h000, 32'd5);
    applyStimulus(12'h008, 32'd3);
    checkRead("ch0_value_start", 12'h004, 32'd5);
    for (int i = 4; i >= 0; i--) pushExpect("ch0_value_count", 32'(i));
    wdogclken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk);
      #1 readReg(12'h004, d);
      checkOutput(d);
    end
    tick(1);
    checkRead("ch0_ris_set", 12'h010, 32'h1);
    checkRead("ch0_reload", 12'h004, 32'd5);
    checkSig("ch0_int_late", 32'(wdogint), 32'h0);
    tick(1);
    checkSig("ch0_int_set", 32'(wdogint), 32'h1);
    checkSig("ch0_any_set", 32'(wdogint_any), 32'h1);
    checkRead("ch0_mis", 12'h014, 32'h1);
    tick(4);
    checkRead("ch0_value_zero", 12'h004, 32'h0);
    checkSig("ch0_res_before", 32'(wdogres), 32'h0);
    tick(1);
    checkSig("ch0_res_set", 32'(wdogres), 32'h1);
    wdogclken = 1'b0;
    applyStimulus(12'h00C, 32'h0);
    checkSig("ch0_res_clr", 32'(wdogres), 32'h0);
    checkRead("ch0_ris_clr", 12'h010, 32'h0);
    checkRead("ch0_value_clr", 12'h004, 32'd5);
    tick(1);
    checkSig("ch0_int_clr", 32'(wdogint), 32'h0);
    applyStimulus(12'h008, 32'h0);

    // Lock blocks channel writes until the key is written again.
    applyStimulus(12'hC00, 32'h0);
    checkRead("lock_read_locked", 12'hC00, 32'h1);
    applyStimulus(12'h020, 32'h10);
    checkRead("ch1_load_locked", 12'h020, 32'hFFFF_FFFF);
    applyStimulus(12'hC00, KEY);
    checkRead("lock_read_unlocked", 12'hC00, 32'h0);
    applyStimulus(12'h020, 32'h10);
    checkRead("ch1_load_unlocked", 12'h020, 32'h10);

    // Channel 2 frozen with INTEN=0, then enabled.
    applyStimulus(12'h040, 32'd3);
    applyStimulus(12'h048, 32'h2);
    wdogclken = 1'b1;
    tick(3);
    checkRead("ch2_frozen", 12'h044, 32'd3);
    checkRead("ch2_ris_frozen", 12'h050, 32'h0);
    checkSig("ch2_int_frozen", 32'(wdogint), 32'h0);
    wdogclken = 1'b0;
    applyStimulus(12'h048, 32'h3);
    checkRead("ch2_enable_reload", 12'h044, 32'd3);
    wdogclken = 1'b1;
    tick(3);
    checkRead("ch2_value_zero", 12'h044, 32'h0);
    tick(1);
    checkRead("ch2_ris_set", 12'h050, 32'h1);
    tick(1);
    checkSig("ch2_int_set", 32'(wdogint), 32'h4);
    checkSig("ch2_any_set", 32'(wdogint_any), 32'h1);
    wdogclken = 1'b0;
    applyStimulus(12'h048, 32'h0);
    applyStimulus(12'h04C, 32'h0);

    // LOAD=0: every enabled tick is a zero event.
    applyStimulus(12'h060, 32'h0);
    applyStimulus(12'h068, 32'h3);
    wdogclken = 1'b1;
    tick(1);
    checkRead("ch3_ris_tick1", 12'h070, 32'h1);
    checkSig("ch3_res_tick1", 32'(wdogres), 32'h0);
    wdogclken = 1'b0;
    tick(1);
    checkSig("ch3_res_idle", 32'(wdogres), 32'h0);
    wdogclken = 1'b1;
    tick(1);
    checkSig("ch3_res_tick2", 32'(wdogres), 32'h8);
    wdogclken = 1'b0;

    // INTCLR on the same edge as a zero event.
    applyStimulus(12'h06C, 32'h0);
    checkRead("ch3_ris_cleared", 12'h070, 32'h0);
    wdogclken = 1'b1;
    applyStimulus(12'h06C, 32'h0);
    wdogclken = 1'b0;
    checkRead("coinc_ris", 12'h070, 32'h1);
    checkSig("coinc_res", 32'(wdogres), 32'h0);

    // Reset while counting with a LOAD write in its access phase.
    applyStimulus(12'h060, 32'h100);
    wdogclken = 1'b1;
    tick(3);
    checkRead("ch3_counting", 12'h064, 32'h0FD);
    preset      = 1'b1;
    apb.psel    = 1'b1;
    apb.penable = 1'b1;
    apb.pwrite  = 1'b1;
    apb.paddr   = 10'h008;
    apb.pwdata  = 32'h55;
    @(posedge pclk);
    #1;
    preset      = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    wdogclken   = 1'b0;
    checkRead("rst_write_lost", 12'h020, 32'hFFFF_FFFF);
    checkRead("rst_ch3_load", 12'h060, 32'hFFFF_FFFF);
    checkRead("rst_ch3_value", 12'h064, 32'hFFFF_FFFF);
    checkRead("rst_ch3_ctrl", 12'h068, 32'h0);
    checkRead("rst_ch3_ris", 12'h070, 32'h0);
    checkSig("rst2_wdogres", 32'(wdogres), 32'h0);
    checkSig("rst2_wdogint", 32'(wdogint), 32'h0);
    tick(1);
    checkRead("id", 12'hC04, {16'h5744, 12'h000, REV});
    checkRead("unmapped", 12'h800, 32'h0);
    checkRead("reserved_off", 12'h018, 32'h0);
    apb.paddr = 10'h301;
    #1 checkSig("psel_low", apb.prdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
